// File: rtl/uart_transmitter.sv
// UART serializer: pops one byte per frame from a FWFT TX FIFO and shifts out
// start, 5-8 data bits LSB first, optional parity and 1-2 stop bits on the baud tick.
module uart_transmitter #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ov_baud_tick_i,
  input  logic [7:0] data_tx_i,
  input  logic       tx_fifo_empty_i,
  output logic       tx_fifo_read_o,
  input  logic [5:0] config_i,
  output logic       tx_o,
  output logic       tx_done_o,
  output logic       tx_idle_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  state_e     state_q;
  logic [7:0] shift_q;
  logic [5:0] cfg_q;
  logic [3:0] tick_q;
  logic [2:0] bit_q;
  logic       par_q;
  logic       tx_q;

  logic       tick_wrap_c;
  logic [2:0] last_data_c;
  logic       parity_en_c;
  logic       last_stop_c;
  logic       pop_c;
  logic [7:0] width_mask_c;

  assign tick_wrap_c  = ov_baud_tick_i && (tick_q == TICK_LAST);
  assign last_data_c  = 3'(cfg_q[5:4]) + 3'd4;
  assign parity_en_c  = ~cfg_q[3];
  assign last_stop_c  = (cfg_q[1:0] == 2'b01) ? (bit_q == 3'd1) : (bit_q == 3'd0);
  assign width_mask_c = 8'(8'hFF >> (2'd3 - config_i[5:4]));

  // Pop is issued in the IDLE cycle itself so the FIFO head is consumed on the latching edge.
  assign pop_c          = rst_n_i && (state_q == S_IDLE) && !tx_fifo_empty_i;
  assign tx_fifo_read_o = pop_c;
  assign tx_done_o      = rst_n_i && (state_q == S_STOP) && tick_wrap_c && last_stop_c;
  assign tx_idle_o      = (state_q == S_IDLE);
  assign tx_o           = tx_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      shift_q <= 8'h00;
      cfg_q   <= 6'h00;
      tick_q  <= 4'd0;
      bit_q   <= 3'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop_c) begin
            shift_q <= data_tx_i;
            cfg_q   <= config_i;
            // Even parity of the active bits, flipped for odd mode.
            par_q   <= (^(data_tx_i & width_mask_c)) ^ config_i[2];
            tick_q  <= 4'd0;
            bit_q   <= 3'd0;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START, S_DATA, S_PARITY, S_STOP: begin
          if (ov_baud_tick_i) begin
            if (tick_q != TICK_LAST) begin
              tick_q <= tick_q + 4'd1;
            end else begin
              tick_q <= 4'd0;
              case (state_q)
                S_START: begin
                  tx_q    <= shift_q[0];
                  bit_q   <= 3'd0;
                  state_q <= S_DATA;
                end
                S_DATA: begin
                  if (bit_q == last_data_c) begin
                    bit_q <= 3'd0;
                    if (parity_en_c) begin
                      tx_q    <= par_q;
                      state_q <= S_PARITY;
                    end else begin
                      tx_q    <= 1'b1;
                      state_q <= S_STOP;
                    end
                  end else begin
                    bit_q   <= bit_q + 3'd1;
                    shift_q <= {1'b0, shift_q[7:1]};
                    tx_q    <= shift_q[1];
                  end
                end
                S_PARITY: begin
                  tx_q    <= 1'b1;
                  bit_q   <= 3'd0;
                  state_q <= S_STOP;
                end
                S_STOP: begin
                  tx_q <= 1'b1;
                  if (last_stop_c) begin
                    bit_q   <= 3'd0;
                    state_q <= S_IDLE;
                  end else begin
                    bit_q <= bit_q + 3'd1;
                  end
                end
                default: begin
                  tx_q    <= 1'b1;
                  state_q <= S_IDLE;
                end
              endcase
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          tick_q  <= 4'd0;
          bit_q   <= 3'd0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
